// File: rtl/key_pkg.sv
// Shared types and default timing constants for the key debouncer.
// Defaults assume a 50 MHz clk and a 1 ms sample tick.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_FILT,
        PRESSED,
        RELEASE_FILT
    } key_st_e;

    localparam int DEF_TICK_DIV   = 50_000;
    localparam int DEF_DEB_TICKS  = 20;
    localparam int DEF_LONG_TICKS = 1000;

endpackage

// File: rtl/key_debounce_if.sv
// Raw key pins in, debounced level and event pulses out.
// master = debouncer side, slave = consumer / pin-driver side.
interface key_debounce_if #(
    parameter int NKEY = 4
);
    logic [NKEY-1:0] key_in;
    logic [NKEY-1:0] key_state;
    logic [NKEY-1:0] key_press;
    logic [NKEY-1:0] key_release;
    logic [NKEY-1:0] key_long;

    modport master (input key_in, output key_state, key_press, key_release, key_long);
    modport slave  (output key_in, input key_state, key_press, key_release, key_long);
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, tick-driven filter FSM, hold counter.
// Latency: 2 clk sync + DEB_TICKS ticks; pulses are combinational in the tick cycle.
// No backpressure: event pulses are fire-and-forget.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int DEB_TICKS      = DEF_DEB_TICKS,
    parameter int LONG_TICKS     = DEF_LONG_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);
    localparam logic IDLE_LVL = (KEY_ACTIVE_LOW != 0);
    localparam int   CW       = $clog2(DEB_TICKS + 1);
    localparam int   HW       = $clog2(LONG_TICKS + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_TICKS - 1);

    logic [1:0]    sync_q;
    logic          p;
    key_st_e       st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [HW-1:0] hold, hold_n;
    logic          press, rel, lng;

    // Sync flops reset to the idle pin level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {2{IDLE_LVL}};
            st     <= IDLE;
            cnt    <= '0;
            hold   <= '0;
        end else begin
            sync_q <= {sync_q[0], key_in};
            st     <= st_n;
            cnt    <= cnt_n;
            hold   <= hold_n;
        end
    end

    assign p = sync_q[1] ^ IDLE_LVL;

    always_comb begin
        st_n   = st;
        cnt_n  = cnt;
        hold_n = hold;
        press  = 1'b0;
        rel    = 1'b0;
        lng    = 1'b0;
        if (tick) begin
            unique case (st)
                IDLE: begin
                    if (p) begin
                        if (DEB_TICKS == 1) begin
                            st_n   = PRESSED;
                            hold_n = '0;
                            press  = 1'b1;
                        end else begin
                            st_n  = PRESS_FILT;
                            cnt_n = CW'(1);
                        end
                    end
                end
                PRESS_FILT: begin
                    if (!p) begin
                        st_n  = IDLE;
                        cnt_n = '0;
                    end else if (cnt == DEB_LAST) begin
                        st_n   = PRESSED;
                        cnt_n  = '0;
                        hold_n = '0;
                        press  = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!p) begin
                        if (DEB_TICKS == 1) begin
                            st_n = IDLE;
                            rel  = 1'b1;
                        end else begin
                            st_n  = RELEASE_FILT;
                            cnt_n = CW'(1);
                        end
                    end else if (hold != HOLD_MAX) begin
                        hold_n = hold + HW'(1);
                        lng    = (hold == HOLD_PRE);
                    end
                end
                RELEASE_FILT: begin
                    // A bounce back to pressed keeps the hold count, so key_long cannot re-arm.
                    if (p) begin
                        st_n  = PRESSED;
                        cnt_n = '0;
                    end else if (cnt == DEB_LAST) begin
                        st_n  = IDLE;
                        cnt_n = '0;
                        rel   = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: st_n = IDLE;
            endcase
        end
    end

    assign key_state   = ~rst & ((st_n == PRESSED) | (st_n == RELEASE_FILT));
    assign key_press   = ~rst & press;
    assign key_release = ~rst & rel;
    assign key_long    = ~rst & lng;

endmodule

// File: rtl/key_debounce.sv
// NKEY-wide key debouncer: shared sample-tick divider feeding one channel per key.
// Latency: 2 clk + (DEB_TICKS-1)*TICK_DIV + up to TICK_DIV of tick phase.
// No backpressure: outputs are free-running levels and single-cycle pulses.
module key_debounce
    import key_pkg::*;
#(
    parameter int NKEY           = 4,
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int TICK_DIV       = DEF_TICK_DIV,
    parameter int DEB_TICKS      = DEF_DEB_TICKS,
    parameter int LONG_TICKS     = DEF_LONG_TICKS
) (
    input  logic           clk,
    input  logic           rst,
    key_debounce_if.master kif
);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    for (genvar i = 0; i < NKEY; i++) begin : g_ch
        key_debounce_ch #(
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW),
            .DEB_TICKS      (DEB_TICKS),
            .LONG_TICKS     (LONG_TICKS)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick        (tick),
            .key_in      (kif.key_in[i]),
            .key_state   (kif.key_state[i]),
            .key_press   (kif.key_press[i]),
            .key_release (kif.key_release[i]),
            .key_long    (kif.key_long[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=10.
// Times are clk cycles k since reset release; ticks fall on k%4==3.
module tb_key_debounce;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_debounce_if #(.NKEY(4)) kif ();

    key_debounce #(
        .NKEY           (4),
        .KEY_ACTIVE_LOW (1),
        .TICK_DIV       (4),
        .DEB_TICKS      (3),
        .LONG_TICKS     (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    int cyc = 0;
    int r0  = 0;
    int n_tests = 0;
    int n_fail  = 0;
    int n_press[4] = '{default: 0};
    int n_rel[4]   = '{default: 0};
    int n_long[4]  = '{default: 0};
    int t_press[4] = '{default: -1};
    int t_rel[4]   = '{default: -1};
    int t_long[4]  = '{default: -1};

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: count every pulse cycle and note when it happened.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (kif.key_press[i] === 1'b1)   begin n_press[i]++; t_press[i] = cyc - r0; end
            if (kif.key_release[i] === 1'b1) begin n_rel[i]++;   t_rel[i]   = cyc - r0; end
            if (kif.key_long[i] === 1'b1)    begin n_long[i]++;  t_long[i]  = cyc - r0; end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, cyc - r0);
        end
    endtask

    task automatic goto(input int k);
        while (cyc - r0 < k) @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        kif.key_in = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_outs_a", {kif.key_state, kif.key_press, kif.key_release, kif.key_long}, 0);
        @(negedge clk);
        chk("rst_outs_b", {kif.key_state, kif.key_press, kif.key_release, kif.key_long}, 0);
        rst = 1'b0;
        r0  = cyc;

        // All keys held through reset: accepted together on the 3rd tick (k=11).
        goto(12);
        for (int i = 0; i < 4; i++) begin
            chk("init_press_n", n_press[i], 1);
            chk("init_press_t", t_press[i], 11);
        end
        chk("init_state", kif.key_state, 4'hF);

        kif.key_in = 4'hF;
        goto(24);
        for (int i = 0; i < 4; i++) begin
            chk("init_rel_n", n_rel[i], 1);
            chk("init_rel_t", t_rel[i], 23);
        end
        chk("idle_state", kif.key_state, 4'h0);

        // Clean press of key0.
        goto(26); kif.key_in[0] = 1'b0;
        goto(40);
        chk("k0_press_n", n_press[0], 2);
        chk("k0_press_t", t_press[0], 39);
        chk("k0_state", kif.key_state, 4'h1);
        chk("others_quiet", n_press[1] + n_press[2] + n_press[3], 3);
        goto(42); kif.key_in[0] = 1'b1;

        // Key1 bounce: 1 tick low, 1 tick high, five times.
        for (int r = 0; r < 5; r++) begin
            goto(44 + 8 * r); kif.key_in[1] = 1'b0;
            goto(48 + 8 * r); kif.key_in[1] = 1'b1;
        end
        goto(84);
        chk("k1_bounce_n", n_press[1], 1);
        chk("k1_bounce_state", kif.key_state[1], 1'b0);
        chk("k0_rel_n", n_rel[0], 2);
        chk("k0_rel_t", t_rel[0], 55);
        kif.key_in[1] = 1'b0;
        goto(96);
        chk("k1_press_n", n_press[1], 2);
        chk("k1_press_t", t_press[1], 95);
        kif.key_in[1] = 1'b1;

        // Long press of key2, released 15 ticks after acceptance.
        goto(110); kif.key_in[2] = 1'b0;
        goto(183);
        chk("k2_press_t", t_press[2], 123);
        chk("k2_long_n", n_long[2], 1);
        chk("k2_long_t", t_long[2], 163);
        kif.key_in[2] = 1'b1;
        goto(196);
        chk("k2_rel_n", n_rel[2], 2);
        chk("k2_rel_t", t_rel[2], 195);
        chk("k2_long_once", n_long[2], 1);
        chk("k1_rel_t", t_rel[1], 107);

        // Key3 held past long, one-tick release bounce.
        goto(200); kif.key_in[3] = 1'b0;
        goto(256);
        chk("k3_long_t", t_long[3], 251);
        kif.key_in[3] = 1'b1;
        goto(260); kif.key_in[3] = 1'b0;
        goto(280);
        chk("k3_bounce_rel", n_rel[3], 1);
        chk("k3_bounce_long", n_long[3], 1);
        chk("k3_held_state", kif.key_state, 4'h8);
        kif.key_in[3] = 1'b1;
        goto(292);
        chk("k3_rel_n", n_rel[3], 2);
        chk("k3_rel_t", t_rel[3], 291);
        chk("k3_long_once", n_long[3], 1);

        // Reset while key0 is held.
        goto(296); kif.key_in[0] = 1'b0;
        goto(308);
        chk("k0_hold_press_t", t_press[0], 307);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outs", {kif.key_state, kif.key_press, kif.key_release, kif.key_long}, 0);
        rst = 1'b0;
        r0  = cyc;
        goto(12);
        chk("midrst_no_rel", n_rel[0], 2);
        chk("midrst_refire_n", n_press[0], 4);
        chk("midrst_refire_t", t_press[0], 11);
        chk("midrst_state", kif.key_state, 4'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
